// File: rtl/xor_stage.sv
// rtl/xor_stage.sv - key/data XOR stage over a 5x64 permutation state, 1-cycle valid/ready register
// Optional input padding of the data block is enabled by defining XOR_STAGE_PAD_EN.
module xor_stage #(
  parameter int KEY_WIDTH  = 128,
  parameter int RATE_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0][63:0]      i_state,
  input  logic [RATE_WIDTH-1:0] i_data,
  input  logic [KEY_WIDTH-1:0]  i_key,
`ifdef XOR_STAGE_PAD_EN
  input  logic [$clog2(RATE_WIDTH/8+1)-1:0] i_nbytes,
`endif
  input  logic [1:0]            i_mode,
  input  logic                  i_xor_lsb,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [4:0][63:0]      o_state,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int STATE_BITS = 320;
  localparam int NB         = RATE_WIDTH / 8;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_DATA     = 2'b01;
  localparam logic [1:0] MODE_INIT_END = 2'b10;
  localparam logic [1:0] MODE_FINAL    = 2'b11;

  logic [4:0][63:0]      state_q, state_d;
  logic                  valid_q, valid_d;
  logic [RATE_WIDTH-1:0] data_pad;
  logic [STATE_BITS-1:0] cat_in, cat_res;
  logic [4:0][63:0]      result;
  logic                  accept;

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;
  assign o_state = state_q;
  assign o_valid = valid_q;

  // Byte 0 is the MSB byte; bytes past the count are zeroed and the first one gets 0x80.
  always_comb begin
    data_pad = i_data;
`ifdef XOR_STAGE_PAD_EN
    for (int b = 0; b < NB; b++) begin
      if (b == int'(i_nbytes))
        data_pad[RATE_WIDTH-1-8*b -: 8] = 8'h80;
      else if (b > int'(i_nbytes))
        data_pad[RATE_WIDTH-1-8*b -: 8] = 8'h00;
    end
`endif
  end

  // cat_in is {state[0], ..., state[4]} with state[0] most significant.
  always_comb begin
    cat_in = '0;
    for (int i = 0; i < 5; i++)
      cat_in[STATE_BITS-1-64*i -: 64] = i_state[i];
  end

  always_comb begin
    cat_res = cat_in;
    case (i_mode)
      MODE_PASS:     cat_res = cat_in;
      MODE_DATA:     cat_res = cat_in ^ {data_pad, {(STATE_BITS-RATE_WIDTH){1'b0}}};
      MODE_INIT_END: cat_res = cat_in ^ {{(STATE_BITS-KEY_WIDTH){1'b0}}, i_key};
      MODE_FINAL:    cat_res = cat_in ^ {{RATE_WIDTH{1'b0}}, i_key,
                                         {(STATE_BITS-RATE_WIDTH-KEY_WIDTH){1'b0}}};
      default:       cat_res = cat_in;
    endcase
    cat_res[0] = cat_res[0] ^ i_xor_lsb;
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < 5; i++)
      result[i] = cat_res[STATE_BITS-1-64*i -: 64];
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (accept) begin
      state_d = result;
      valid_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

endmodule
